// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-4 Booth multiplier, one digit per clock, Hi/Lo product
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi
);

  localparam int AW = 2*WIDTH + 2;
  localparam int BW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH/2 + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [BW-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   ndig;
  logic [AW-1:0]   term;
  logic            launch;
  logic            last;

  assign launch = (state != RUN) && start;
  assign last   = (cnt == ndig);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mcand already carries the 2i shift, so the digit only picks the multiple
  always_comb begin
    term = '0;
    case (mplier[2:0])
      3'b001, 3'b010: term = mcand;
      3'b011:         term = mcand << 1;
      3'b100:         term = -(mcand << 1);
      3'b101, 3'b110: term = -mcand;
      default:        term = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      ndig   <= '0;
      Hi     <= '0;
      Lo     <= '0;
    end else if (launch) begin
      acc    <= '0;
      cnt    <= '0;
      mcand  <= {{(AW-WIDTH){A[WIDTH-1] & signed_mode}}, A};
      // two extension bits on top, implicit B[-1]=0 at the bottom
      mplier <= {{2{B[WIDTH-1] & signed_mode}}, B, 1'b0};
      ndig   <= signed_mode ? CW'(WIDTH/2) : CW'(WIDTH/2 + 1);
    end else if (state == RUN) begin
      if (last) begin
        {Hi, Lo} <= acc[2*WIDTH-1:0];
      end else begin
        acc    <= acc + term;
        mcand  <= mcand << 2;
        mplier <= mplier >> 2;
        cnt    <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - bench for booth_mul_seq at WIDTH=32 and WIDTH=8
module tb_booth_mul_seq;

  logic        clock;
  logic        reset_n;

  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32, lo32, hi32;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8, lo8, hi8;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .start(start32), .signed_mode(sm32),
    .A(a32), .B(b32), .busy(busy32), .done(done32), .Lo(lo32), .Hi(hi32)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .Lo(lo8), .Hi(hi8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input bit sm, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sm ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sm ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input bit sm, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = sm ? {{8{a[7]}}, a} : {8'b0, a};
    eb = sm ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  function automatic int lat_exp(input bit sm, input int w);
    return w/2 + (sm ? 0 : 1) + 1;
  endfunction

  task automatic op32(input bit sm, input logic [31:0] a, input logic [31:0] b,
                      output logic [63:0] prod, output int lat);
    @(negedge clock);
    start32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
    @(negedge clock);
    start32 = 1'b0; sm32 = ~sm; a32 = $urandom; b32 = $urandom;
    chk("busy_in_run", {63'b0, busy32}, 64'd1);
    lat = 0;
    while (!done32 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    prod = {hi32, lo32};
    @(negedge clock);
    chk("done_one_cycle", {62'b0, done32, busy32}, 64'd0);
  endtask

  logic [15:0] exp_q[$];
  int          gap_q[$];
  logic [15:0] corners[8];
  int          issued;
  localparam int TOTAL8 = 2016;

  task automatic issue8();
    logic [7:0] a, b;
    bit         sm;
    if (issued < 16) begin
      a  = corners[issued % 8][15:8];
      b  = corners[issued % 8][7:0];
      sm = (issued >= 8);
    end else begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      sm = 1'($urandom);
    end
    a8 = a; b8 = b; sm8 = sm;
    exp_q.push_back(ref8(sm, a, b));
    gap_q.push_back(lat_exp(sm, 8) + 1);
    issued++;
  endtask

  initial begin
    logic [63:0] prod, prev;
    int          lat, ndone, cyc, last_done, completed, g;
    logic [15:0] e8;

    tbl[0] = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tbl[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[4] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    tbl[5] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    tbl[6] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    tbl[7] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    tbl[8] = '{1'b0, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
    tbl[9] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    corners[0] = 16'h8080; corners[1] = 16'h807F; corners[2] = 16'h7F7F; corners[3] = 16'hFFFF;
    corners[4] = 16'h8001; corners[5] = 16'h00FF; corners[6] = 16'h0180; corners[7] = 16'hFF80;

    reset_n = 1'b0;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    #1;
    chk("reset32", {busy32, done32, hi32, lo32}, 64'd0);
    chk("reset8",  {46'b0, busy8, done8, hi8, lo8}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      op32(tbl[i].sm, tbl[i].a, tbl[i].b, prod, lat);
      chk($sformatf("tbl%0d_prod", i), prod, {tbl[i].hi, tbl[i].lo});
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(lat_exp(tbl[i].sm, 32)));
    end

    // start pulse during RUN is ignored; Hi/Lo hold until the done cycle
    prev = {hi32, lo32};
    @(negedge clock);
    start32 = 1'b1; sm32 = 1'b1; a32 = 32'd6; b32 = 32'd7;
    @(negedge clock);
    start32 = 1'b0;
    lat = 0; ndone = 0;
    while (!done32 && lat < 100) begin
      chk("hold_during_run", {hi32, lo32}, prev);
      if (lat == 5) begin start32 = 1'b1; a32 = 32'd9; b32 = 32'd9; end
      else start32 = 1'b0;
      @(negedge clock);
      lat++;
    end
    start32 = 1'b0;
    chk("ignored_start_prod", {hi32, lo32}, 64'h2A);
    chk("ignored_start_lat", 64'(lat), 64'(lat_exp(1'b1, 32)));
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (done32) ndone++;
    end
    chk("single_done", 64'(ndone), 64'd0);
    chk("hold_after_done", {hi32, lo32}, 64'h2A);

    // async reset mid-RUN aborts the op
    @(negedge clock);
    start32 = 1'b1; sm32 = 1'b0; a32 = 32'd123457; b32 = 32'd99;
    @(negedge clock);
    start32 = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outputs", {busy32, done32, hi32, lo32}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (done32) ndone++;
    end
    chk("no_done_after_abort", 64'(ndone), 64'd0);
    op32(1'b0, 32'd123457, 32'd99, prod, lat);
    chk("op_after_abort", prod, 64'd12222243);

    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra, rb;
      bit          rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      op32(rs, ra, rb, prod, lat);
      chk("rand32_prod", prod, ref32(rs, ra, rb));
      chk("rand32_lat", 64'(lat), 64'(lat_exp(rs, 32)));
    end

    // WIDTH=8 with start held high: back-to-back ops
    issued = 0; completed = 0; last_done = -1; cyc = 0;
    @(negedge clock);
    issue8();
    start8 = 1'b1;
    while (completed < TOTAL8 && cyc < 40000) begin
      @(negedge clock);
      cyc++;
      if (done8) begin
        e8 = exp_q.pop_front();
        g  = gap_q.pop_front();
        chk("w8_prod", {48'b0, hi8, lo8}, {48'b0, e8});
        if (last_done >= 0) chk("w8_gap", 64'(cyc - last_done), 64'(g));
        last_done = cyc;
        completed++;
        if (issued < TOTAL8) issue8();
        else start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    chk("w8_completed", 64'(completed), 64'(TOTAL8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
